mpt_parsing_stage_q: RTL and testbench
======================================

# mpt_parsing_stage_q

Parametrised successor to the MPT walker's per-level parsing stage. It accepts one walked MPT entry per transaction, checks the entry format and leaf permissions, and computes the next-level MPTE address. It queues results in an internal FIFO of configurable depth, so that `stage_slave_ready` has no combinational path from `stage_master_ready`. It also provides a sticky first-error capture and a saturating fault counter for debug. One instance sits between each walking stage and the next; `WALKING_LEVEL` selects the level.

## Interface
- `WALKING_LEVEL`, 0: level handled by this instance (0 = leaf-only level).
- `DATA_WIDTH`, `$bits(mptw_transaction_t)`: width of both data ports.
- `FIFO_DEPTH`, 2: output queue entries; a power of two, ≥2.
- `SUPPORTED_MODES`, 3'b111: enable mask, bit0 = SMMPT43, bit1 = SMMPT52, bit2 = SMMPT64.
- `CNT_WIDTH`, 16: fault counter width.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `stage_slave_data` in `DATA_WIDTH`: incoming `mptw_transaction_t`, with `mpte` holding the fetched entry.
- `stage_slave_valid` in 1 / `stage_slave_ready` out 1: input handshake.
- `stage_master_data` out `DATA_WIDTH`: processed transaction at the queue head.
- `stage_master_valid` out 1 / `stage_master_ready` in 1: output handshake.
- `access_page_fault_o` out 1: access fault of the head entry, qualified by `stage_master_valid`.
- `format_error_cause_o` out `page_format_fault_e`: format cause of the head entry; `NO_ERROR` when the queue is empty.
- `err_clear_i` in 1: clears the sticky capture.
- `err_valid_o` out 1, `err_id_o` out id width, `err_cause_o` out `page_format_fault_e`, `err_access_o` out 1: first captured fault.
- `fault_count_o` out `CNT_WIDTH`: saturating count of faulted transactions.

## Operation
- **Root level R(mode):** 2 for SMMPT43, 3 for SMMPT52, 4 for SMMPT64.
- **Page-number fields:** PN_i = spa[16+9i +: 9]. For SMMPT64 PN4, only the low 9 bits are used.
- **Pass-through:** an input with `valid`=0, `completed`=1, or `WALKING_LEVEL`>R is forwarded unchanged. It raises no errors and is not counted.
- **Unsupported mode:** a mode not enabled in `SUPPORTED_MODES` produces cause `UNSUPPORTED_MODE` and `completed`=1.
- **Level == R:** base = mmpt.PPN×PAGESIZE. The entry is treated as non-leaf, and no format check is applied.
- **Level < R, format checks in priority order:**
  - `!V` → `NOT_VALID_ENTRY`.
  - Any reserved field ≠0 (common, or leaf/non-leaf variant) → `RESERVED_BITS_USED`.
  - Non-leaf at level 0 → `LEVEL_UNDERFLOW`.
- **Non-leaf, no error:** `mpte` ← base + PN_L×MPTESIZE, where base = entry PPN×PAGESIZE. Arithmetic is XLEN-wide, and overflow wraps.
- **Leaf:**
  - Range offset = top `NUMPGINRANGE` bits of PN_(L-1) for L>0, or of spa[15:0] for L=0.
  - perm = PERMS[offset].
  - Read requires an R-containing encoding, write requires RW or RWX, exec requires an X-containing encoding.
  - A mismatch sets the access fault.
- **Output transaction fields:**
  - `completed` = leaf | any error | L==0 | input `completed`.
  - `walking` = `MPT_WALKING_SKIP` if `completed`, otherwise the input value.
  - `format_error` and `access_error` are set to this stage's results if the input carried none; otherwise the input values are kept.
  - All other fields are copied unchanged.
- **Queue:** a parsed result, including its error bits, is written on slave fire. A pop happens on master fire.
- **Sticky capture:** the first faulted transaction loads `err_*`, and later faults are ignored until `err_clear_i`. If clear and a new fault occur in the same cycle, the new fault is captured.
- **Counter:** `fault_count_o` increments on each pushed faulted transaction and saturates at all-ones.

## Timing
- **Reset values:** queue empty, `stage_master_valid`=0, `stage_slave_ready`=1, `err_valid_o`=0, `err_*`=0, `fault_count_o`=0. `format_error_cause_o`=`NO_ERROR` and `access_page_fault_o`=0 while the queue is empty.
- **Reset mid-operation:** all queued entries are discarded.
- **Latency:** 1 cycle from slave fire to `stage_master_valid` when the queue is empty.
- **Throughput:** 1 transaction per cycle sustained while `stage_master_ready`=1.
- **`stage_slave_ready`:** registered; equals !full. When full, a simultaneous pop does not raise ready in the same cycle; ready rises the following cycle.
- **`stage_master_valid`:** equals !empty. The head data is stable until popped.
- **Error outputs:** `access_page_fault_o`, `format_error_cause_o` and `err_*` are registered. They change only on clock edges.

## Structure
- **In `mpt_pkg`:**
  - Root-level constants per mode.
  - `PN_W`=9, `PN_BASE`=16.
  - Permission-encoding sets.
  - Helper function `pn_field(spa, level)`.
- **Sub-module `mpt_sync_fifo`:** parameters `DATA_WIDTH` and `DEPTH`; registered full/empty; pointers one bit wider than the address for wrap detection.
- **This module:** parse logic is combinational; capture and counter are in this module.

## Test plan
- SMMPT43, L=2, mmpt.PPN=0x100, PN2=5 → `mpte`=0x100005×… i.e. 0x100000+5×8=0x100028. `completed`=0, `walking` unchanged, latency 1.
- L=1, entry V=0 → `format_error_cause_o`=`NOT_VALID_ENTRY`, `completed`=1, `walking`=SKIP, `err_valid_o`=1, `fault_count_o`=1.
- L=0 leaf, perm=R-only, write access → `access_page_fault_o`=1; the same stimulus with a read access → no fault.
- FIFO_DEPTH=2, `stage_master_ready`=0, 3 pushes → `stage_slave_ready` drops after the 2nd push. Release ready → data pops in order.
- Two faults, then `err_clear_i` coinciding with a third fault → `err_id_o` = first fault's id until the clear, then the third fault's id.
- Mode outside `SUPPORTED_MODES` → `UNSUPPORTED_MODE`. Counter preset near saturation → `fault_count_o` holds at all-ones.

Source files
------------

// File: rtl/mpt_pkg.sv
// Shared types, field layout and helpers for the MPT walker stages.
package mpt_pkg;

  localparam int XLEN         = 64;
  localparam int PN_W         = 9;
  localparam int PN_BASE      = 16;
  localparam int PAGE_SHIFT   = 12;  // PAGESIZE = 4 KiB
  localparam int MPTE_SHIFT   = 3;   // MPTESIZE = 8 bytes
  localparam int NUMPGINRANGE = 4;   // 16 pages share one leaf entry
  localparam int PPN_W        = 44;
  localparam int ID_W         = 4;

  localparam int ROOT_SMMPT43 = 2;
  localparam int ROOT_SMMPT52 = 3;
  localparam int ROOT_SMMPT64 = 4;

  // MPTE layout: V, L, common reserved, then leaf perms or non-leaf PPN.
  localparam int MPTE_V        = 0;
  localparam int MPTE_L        = 1;
  localparam int PERM_LSB      = 8;
  localparam int PPN_LSB       = 8;

  // 3-bit permission encodings {X, W, R}.
  localparam logic [2:0] PERM_R   = 3'b001;
  localparam logic [2:0] PERM_RW  = 3'b011;
  localparam logic [2:0] PERM_X   = 3'b100;
  localparam logic [2:0] PERM_RX  = 3'b101;
  localparam logic [2:0] PERM_RWX = 3'b111;

  typedef enum logic [1:0] {
    MODE_BARE = 2'd0, SMMPT43 = 2'd1, SMMPT52 = 2'd2, SMMPT64 = 2'd3
  } mpt_mode_e;

  typedef enum logic [1:0] {
    MPT_WALKING_SKIP = 2'd0, MPT_WALKING_ACTIVE = 2'd1, MPT_WALKING_RETRY = 2'd2
  } mpt_walking_e;

  typedef enum logic [2:0] {
    NO_ERROR = 3'd0, NOT_VALID_ENTRY = 3'd1, RESERVED_BITS_USED = 3'd2,
    LEVEL_UNDERFLOW = 3'd3, UNSUPPORTED_MODE = 3'd4
  } page_format_fault_e;

  typedef struct packed {
    logic               valid;
    logic               completed;
    mpt_walking_e       walking;
    logic [ID_W-1:0]    id;
    mpt_mode_e          mode;
    logic [PPN_W-1:0]   mmpt_ppn;
    logic [XLEN-1:0]    spa;
    logic [2:0]         access;      // {exec, write, read}
    logic [XLEN-1:0]    mpte;
    page_format_fault_e format_error;
    logic               access_error;
  } mptw_transaction_t;

  function automatic logic [PN_W-1:0] pn_field(input logic [XLEN-1:0] spa, input int level);
    return spa[PN_BASE + PN_W*level +: PN_W];
  endfunction

  function automatic int root_level(input mpt_mode_e mode);
    case (mode)
      SMMPT52: return ROOT_SMMPT52;
      SMMPT64: return ROOT_SMMPT64;
      default: return ROOT_SMMPT43;
    endcase
  endfunction

  function automatic logic mode_supported(input mpt_mode_e mode, input logic [2:0] mask);
    case (mode)
      SMMPT43: return mask[0];
      SMMPT52: return mask[1];
      SMMPT64: return mask[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic perm_read(input logic [2:0] p);
    return p inside {PERM_R, PERM_RW, PERM_RX, PERM_RWX};
  endfunction

  function automatic logic perm_write(input logic [2:0] p);
    return p inside {PERM_RW, PERM_RWX};
  endfunction

  function automatic logic perm_exec(input logic [2:0] p);
    return p inside {PERM_X, PERM_RX, PERM_RWX};
  endfunction

endpackage

// File: rtl/mpt_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered full/empty flags.
module mpt_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic        do_push, do_pop;

  assign do_push     = push & ~full;
  assign do_pop      = pop & ~empty;
  assign wr_ptr_next = wr_ptr + {{AW{1'b0}}, do_push};
  assign rd_ptr_next = rd_ptr + {{AW{1'b0}}, do_pop};
  assign dout        = mem[rd_ptr[AW-1:0]];

  // Pointers and flags; flags come from next-state pointers so they stay registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      full   <= (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
      empty  <= (wr_ptr_next == rd_ptr_next);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mpt_parsing_stage_q.sv
// One MPT walk level: parses the fetched entry, queues the result, tracks faults.
module mpt_parsing_stage_q
  import mpt_pkg::*;
#(
  parameter int         WALKING_LEVEL   = 0,
  parameter int         DATA_WIDTH      = $bits(mptw_transaction_t),
  parameter int         FIFO_DEPTH      = 2,
  parameter logic [2:0] SUPPORTED_MODES = 3'b111,
  parameter int         CNT_WIDTH       = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] stage_slave_data,
  input  logic                  stage_slave_valid,
  output logic                  stage_slave_ready,
  output logic [DATA_WIDTH-1:0] stage_master_data,
  output logic                  stage_master_valid,
  input  logic                  stage_master_ready,
  output logic                  access_page_fault_o,
  output page_format_fault_e    format_error_cause_o,
  input  logic                  err_clear_i,
  output logic                  err_valid_o,
  output logic [ID_W-1:0]       err_id_o,
  output page_format_fault_e    err_cause_o,
  output logic                  err_access_o,
  output logic [CNT_WIDTH-1:0]  fault_count_o
);
  localparam int PREV_LEVEL = (WALKING_LEVEL > 0) ? WALKING_LEVEL - 1 : 0;

  mptw_transaction_t  in_txn, out_txn, head_txn;
  page_format_fault_e cause;
  logic               acc_fault, leaf, pass, fault, fire, full, empty;
  logic [XLEN-1:0]    entry;
  logic [PN_W-1:0]    pn_cur, pn_prev;
  logic [3:0]         offset;
  logic [2:0]         perm;

  assign in_txn = stage_slave_data;
  assign entry  = in_txn.mpte;

  // Combinational parse of one entry into the outgoing transaction.
  always_comb begin
    out_txn   = in_txn;
    cause     = NO_ERROR;
    acc_fault = 1'b0;
    leaf      = 1'b0;
    pass      = 1'b0;
    pn_cur    = pn_field(in_txn.spa, WALKING_LEVEL);
    pn_prev   = pn_field(in_txn.spa, PREV_LEVEL);
    offset    = (WALKING_LEVEL > 0) ? pn_prev[PN_W-1 -: NUMPGINRANGE]
                                    : in_txn.spa[15 -: NUMPGINRANGE];
    perm      = entry[PERM_LSB + 3*int'(offset) +: 3];
    if (!in_txn.valid || in_txn.completed) begin
      pass = 1'b1;
    end else if (!mode_supported(in_txn.mode, SUPPORTED_MODES)) begin
      cause = UNSUPPORTED_MODE;
    end else if (WALKING_LEVEL > root_level(in_txn.mode)) begin
      pass = 1'b1;
    end else if (WALKING_LEVEL == root_level(in_txn.mode)) begin
      out_txn.mpte = ({{(XLEN-PPN_W){1'b0}}, in_txn.mmpt_ppn} << PAGE_SHIFT)
                   + ({{(XLEN-PN_W){1'b0}}, pn_cur} << MPTE_SHIFT);
    end else if (!entry[MPTE_V]) begin
      cause = NOT_VALID_ENTRY;
    end else if (entry[7:2] != '0 ||
                 (entry[MPTE_L] ? (entry[63:56] != '0) : (entry[63:52] != '0))) begin
      cause = RESERVED_BITS_USED;
    end else if (!entry[MPTE_L] && WALKING_LEVEL == 0) begin
      cause = LEVEL_UNDERFLOW;
    end else if (entry[MPTE_L]) begin
      leaf      = 1'b1;
      acc_fault = (in_txn.access[0] & ~perm_read(perm)) |
                  (in_txn.access[1] & ~perm_write(perm)) |
                  (in_txn.access[2] & ~perm_exec(perm));
    end else begin
      out_txn.mpte = ({{(XLEN-PPN_W){1'b0}}, entry[PPN_LSB +: PPN_W]} << PAGE_SHIFT)
                   + ({{(XLEN-PN_W){1'b0}}, pn_cur} << MPTE_SHIFT);
    end
    if (!pass) begin
      out_txn.completed = leaf | (cause != NO_ERROR) | acc_fault |
                          (WALKING_LEVEL == 0) | in_txn.completed;
      if (out_txn.completed) out_txn.walking = MPT_WALKING_SKIP;
      if (in_txn.format_error == NO_ERROR && !in_txn.access_error) begin
        out_txn.format_error = cause;
        out_txn.access_error = acc_fault;
      end
    end
  end

  assign fault = (cause != NO_ERROR) | acc_fault;
  assign fire  = stage_slave_valid & stage_slave_ready;

  mpt_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (fire),
    .din   (out_txn),
    .pop   (stage_master_ready),
    .dout  (stage_master_data),
    .full  (full),
    .empty (empty)
  );

  assign head_txn             = stage_master_data;
  assign stage_slave_ready    = ~full;
  assign stage_master_valid   = ~empty;
  assign access_page_fault_o  = ~empty & head_txn.access_error;
  assign format_error_cause_o = empty ? NO_ERROR : head_txn.format_error;

  // Sticky first-fault capture; a fault arriving with the clear wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_valid_o  <= 1'b0;
      err_id_o     <= '0;
      err_cause_o  <= NO_ERROR;
      err_access_o <= 1'b0;
    end else if (fire && fault && (err_clear_i || !err_valid_o)) begin
      err_valid_o  <= 1'b1;
      err_id_o     <= in_txn.id;
      err_cause_o  <= cause;
      err_access_o <= acc_fault;
    end else if (err_clear_i) begin
      err_valid_o  <= 1'b0;
      err_id_o     <= '0;
      err_cause_o  <= NO_ERROR;
      err_access_o <= 1'b0;
    end
  end

  // Saturating count of pushed faulted transactions.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fault_count_o <= '0;
    else if (fire && fault && fault_count_o != '1) fault_count_o <= fault_count_o + 1'b1;
  end

endmodule

// File: tb/tb_mpt_parsing_stage_q.sv
// Directed bench: three stages at levels 0, 1 and 2 sharing one input bus.
module tb_mpt_parsing_stage_q;
  import mpt_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mptw_transaction_t  s_data;
  logic [2:0]         s_valid = '0;
  logic               m_ready = 1'b1;
  logic               err_clear = 1'b0;
  logic [2:0]         s_ready, m_valid, apf, err_valid, err_access;
  mptw_transaction_t  m_data [3];
  page_format_fault_e cause [3];
  page_format_fault_e err_cause [3];
  logic [ID_W-1:0]    err_id [3];
  logic [2:0]         cnt [3];

  int checks = 0;
  int errors = 0;

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_dut
    mpt_parsing_stage_q #(
      .WALKING_LEVEL(gi), .FIFO_DEPTH(2), .SUPPORTED_MODES(3'b011), .CNT_WIDTH(3)
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .stage_slave_data(s_data), .stage_slave_valid(s_valid[gi]), .stage_slave_ready(s_ready[gi]),
      .stage_master_data(m_data[gi]), .stage_master_valid(m_valid[gi]), .stage_master_ready(m_ready),
      .access_page_fault_o(apf[gi]), .format_error_cause_o(cause[gi]),
      .err_clear_i(err_clear), .err_valid_o(err_valid[gi]), .err_id_o(err_id[gi]),
      .err_cause_o(err_cause[gi]), .err_access_o(err_access[gi]), .fault_count_o(cnt[gi])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic mptw_transaction_t mk(input logic [3:0] id, input mpt_mode_e mode,
                                           input logic [43:0] ppn, input logic [63:0] spa,
                                           input logic [2:0] acc, input logic [63:0] mpte);
    mptw_transaction_t t;
    t.valid = 1'b1;  t.completed = 1'b0;  t.walking = MPT_WALKING_ACTIVE;
    t.id = id;  t.mode = mode;  t.mmpt_ppn = ppn;  t.spa = spa;  t.access = acc;
    t.mpte = mpte;  t.format_error = NO_ERROR;  t.access_error = 1'b0;
    return t;
  endfunction

  // One-cycle push; results are visible at the negedge that ends the task.
  task automatic push(input int inst, input mptw_transaction_t t, input logic clr);
    @(negedge clk);
    s_data = t;  s_valid[inst] = 1'b1;  err_clear = clr;
    @(negedge clk);
    s_valid = '0;  err_clear = 1'b0;
    $display("txn inst=%0d id=%0h mode=%0d spa=%0h mpte_in=%0h clr=%0b",
             inst, t.id, t.mode, t.spa, t.mpte, clr);
  endtask

  mptw_transaction_t t;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    s_data = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_s_ready", 64'(s_ready[i]), 64'd1);
      check("rst_m_valid", 64'(m_valid[i]), 64'd0);
      check("rst_err_valid", 64'(err_valid[i]), 64'd0);
      check("rst_cnt", 64'(cnt[i]), 64'd0);
      check("rst_cause", 64'(cause[i]), 64'(NO_ERROR));
      check("rst_apf", 64'(apf[i]), 64'd0);
    end
    rst_n = 1'b1;

    // Root level of SMMPT43: 0x100 pages + PN2(5)*8.
    push(2, mk(4'd1, SMMPT43, 44'h100, 64'd5 << 34, 3'b001, 64'h0), 1'b0);
    check("root_latency", 64'(m_valid[2]), 64'd1);
    check("root_mpte", m_data[2].mpte, 64'h100028);
    check("root_completed", 64'(m_data[2].completed), 64'd0);
    check("root_walking", 64'(m_data[2].walking), 64'(MPT_WALKING_ACTIVE));
    check("root_cause", 64'(cause[2]), 64'(NO_ERROR));

    // Level 1, invalid entry.
    push(1, mk(4'd3, SMMPT43, 44'h0, 64'h0, 3'b001, 64'h0), 1'b0);
    check("nv_cause", 64'(cause[1]), 64'(NOT_VALID_ENTRY));
    check("nv_completed", 64'(m_data[1].completed), 64'd1);
    check("nv_walking", 64'(m_data[1].walking), 64'(MPT_WALKING_SKIP));
    check("nv_err_valid", 64'(err_valid[1]), 64'd1);
    check("nv_err_id", 64'(err_id[1]), 64'd3);
    check("nv_err_cause", 64'(err_cause[1]), 64'(NOT_VALID_ENTRY));
    check("nv_cnt", 64'(cnt[1]), 64'd1);

    // Level 1, reserved bit 60 in a non-leaf; first fault stays captured.
    push(1, mk(4'd4, SMMPT43, 44'h0, 64'h0, 3'b001, 64'h1000_0000_0000_0001), 1'b0);
    check("rsv_cause", 64'(cause[1]), 64'(RESERVED_BITS_USED));
    check("rsv_sticky_id", 64'(err_id[1]), 64'd3);
    check("rsv_cnt", 64'(cnt[1]), 64'd2);

    // Level 1 non-leaf: PPN 2 -> 0x2000 + PN1(7)*8.
    push(1, mk(4'd2, SMMPT43, 44'h0, 64'd7 << 25, 3'b001, 64'h201), 1'b0);
    check("nl_mpte", m_data[1].mpte, 64'h2038);
    check("nl_completed", 64'(m_data[1].completed), 64'd0);
    check("nl_cause", 64'(cause[1]), 64'(NO_ERROR));

    // Level 0 leaf, offset 3 has R-only permission.
    push(0, mk(4'd8, SMMPT43, 44'h0, 64'h3000, 3'b010, 64'h20003), 1'b0);
    check("leaf_w_apf", 64'(apf[0]), 64'd1);
    check("leaf_w_cause", 64'(cause[0]), 64'(NO_ERROR));
    check("leaf_w_completed", 64'(m_data[0].completed), 64'd1);
    check("leaf_w_err_access", 64'(err_access[0]), 64'd1);
    push(0, mk(4'd9, SMMPT43, 44'h0, 64'h3000, 3'b001, 64'h20003), 1'b0);
    check("leaf_r_apf", 64'(apf[0]), 64'd0);
    check("leaf_r_cnt", 64'(cnt[0]), 64'd1);

    // Level 0 non-leaf underflows.
    push(0, mk(4'd10, SMMPT43, 44'h0, 64'h0, 3'b001, 64'h1), 1'b0);
    check("uf_cause", 64'(cause[0]), 64'(LEVEL_UNDERFLOW));
    check("uf_cnt", 64'(cnt[0]), 64'd2);

    // Completed input passes through untouched.
    t = mk(4'd11, SMMPT43, 44'h5, 64'h1234, 3'b111, 64'h0);
    t.completed = 1'b1;
    push(0, t, 1'b0);
    check("pass_equal", 64'(m_data[0] == t), 64'd1);
    check("pass_cnt", 64'(cnt[0]), 64'd2);

    // Queue fill with no pop, then drain in order.
    m_ready = 1'b0;
    @(negedge clk);
    s_data = mk(4'd10, SMMPT43, 44'h1, 64'h0, 3'b001, 64'h0);  s_valid[2] = 1'b1;
    @(negedge clk);
    check("fifo_ready_after1", 64'(s_ready[2]), 64'd1);
    s_data = mk(4'd11, SMMPT43, 44'h1, 64'h0, 3'b001, 64'h0);
    @(negedge clk);
    check("fifo_ready_full", 64'(s_ready[2]), 64'd0);
    check("fifo_head_a", 64'(m_data[2].id), 64'd10);
    s_data = mk(4'd12, SMMPT43, 44'h1, 64'h0, 3'b001, 64'h0);
    m_ready = 1'b1;
    @(negedge clk);
    check("fifo_ready_rise", 64'(s_ready[2]), 64'd1);
    check("fifo_head_b", 64'(m_data[2].id), 64'd11);
    @(negedge clk);
    check("fifo_head_c", 64'(m_data[2].id), 64'd12);
    s_valid = '0;
    @(negedge clk);
    check("fifo_drained", 64'(m_valid[2]), 64'd0);
    $display("txn inst=2 fifo fill/drain ids a,b,c");

    // Sticky capture with clear.
    @(negedge clk);  err_clear = 1'b1;
    @(negedge clk);  err_clear = 1'b0;
    check("clr_err_valid", 64'(err_valid[1]), 64'd0);
    push(1, mk(4'd5, SMMPT43, 44'h0, 64'h0, 3'b001, 64'h0), 1'b0);
    push(1, mk(4'd6, SMMPT43, 44'h0, 64'h0, 3'b001, 64'h0), 1'b0);
    check("stk_first_id", 64'(err_id[1]), 64'd5);
    push(1, mk(4'd7, SMMPT43, 44'h0, 64'h0, 3'b001, 64'h0), 1'b1);
    check("stk_clr_new_id", 64'(err_id[1]), 64'd7);
    check("stk_clr_valid", 64'(err_valid[1]), 64'd1);
    check("stk_cnt", 64'(cnt[1]), 64'd5);

    // Unsupported mode, then counter saturation.
    push(1, mk(4'd13, SMMPT64, 44'h0, 64'h0, 3'b001, 64'h201), 1'b0);
    check("um_cause", 64'(cause[1]), 64'(UNSUPPORTED_MODE));
    check("um_completed", 64'(m_data[1].completed), 64'd1);
    check("um_cnt", 64'(cnt[1]), 64'd6);
    for (int k = 0; k < 3; k++)
      push(1, mk(4'd14, SMMPT64, 44'h0, 64'h0, 3'b001, 64'h201), 1'b0);
    check("sat_cnt", 64'(cnt[1]), 64'd7);

    // Reset while queue holds data.
    m_ready = 1'b0;
    push(2, mk(4'd1, SMMPT43, 44'h1, 64'h0, 3'b001, 64'h0), 1'b0);
    check("mid_valid_before", 64'(m_valid[2]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(m_valid[2]), 64'd0);
    check("mid_rst_ready", 64'(s_ready[2]), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
